// File: rtl/lfsr_pkg.sv
// Shared constants and the next-state function for the 16-bit Fibonacci LFSR
// (polynomial x^16 + x^14 + x^13 + x^11 + 1).
package lfsr_pkg;

  localparam int WIDTH = 16;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  // All-zero is the lock-up state, so a zero seed request is replaced by this.
  localparam logic [WIDTH-1:0] DEFAULT_SEED = 16'hABCD;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[WIDTH-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr16_dff_r.sv
// Generic W-bit D register. Synchronous active-high reset loads rst_val,
// which may be a live signal rather than a constant.
module dff_r #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= rst_val;
    else       q <= d;
  end

endmodule

// File: rtl/lfsr16.sv
// 16-bit maximal-length LFSR with seed capture and a one-cycle wrap pulse each
// time the sequence returns to the captured seed. All outputs are registered.
module lfsr16 #(
  parameter int               WIDTH        = lfsr_pkg::WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             enable,
  output logic [WIDTH-1:0] state,
  output logic             wrap,
  output logic [WIDTH-1:0] step_cnt
);

  import lfsr_pkg::lfsr_next;

  logic [WIDTH-1:0] seed_sel;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] next_state;
  logic             hit;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_d;

  // Reset path: zero would lock the register, so it is never loaded.
  assign seed_sel   = (seed_in == '0) ? DEFAULT_SEED : seed_in;
  assign next_state = lfsr_next(state);
  assign hit        = (next_state == seed_q);

  // Run/hold mux; reset priority lives inside the registers.
  always_comb begin
    state_d = state;
    cnt_d   = step_cnt;
    wrap_d  = 1'b0;
    if (enable) begin
      state_d = next_state;
      cnt_d   = hit ? '0 : step_cnt + 1'b1;
      wrap_d  = hit;
    end
  end

  dff_r #(.W(WIDTH)) u_state (
    .clk     (clk),
    .reset   (reset),
    .rst_val (seed_sel),
    .d       (state_d),
    .q       (state)
  );

  dff_r #(.W(WIDTH)) u_seed (
    .clk     (clk),
    .reset   (reset),
    .rst_val (seed_sel),
    .d       (seed_q),
    .q       (seed_q)
  );

  dff_r #(.W(WIDTH)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .rst_val ('0),
    .d       (cnt_d),
    .q       (step_cnt)
  );

  dff_r #(.W(1)) u_wrap (
    .clk     (clk),
    .reset   (reset),
    .rst_val (1'b0),
    .d       (wrap_d),
    .q       (wrap)
  );

endmodule

// File: tb/tb_lfsr16.sv
// Directed and randomized bench for lfsr16 against an arithmetic reference
// model of the shift register, seed capture, step counter and wrap pulse.
module tb_lfsr16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] seed_in;
  logic        enable;
  logic [15:0] state;
  logic        wrap;
  logic [15:0] step_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] m_state, m_seed, m_cnt;
  logic        m_wrap;
  logic [15:0] exp_q[$];
  bit          seen[0:65535];

  lfsr16 dut (
    .clk      (clk),
    .reset    (reset),
    .seed_in  (seed_in),
    .enable   (enable),
    .state    (state),
    .wrap     (wrap),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  // Feedback is the parity of the tapped bits (15,13,12,10 -> mask 0xB400).
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    int unsigned fb;
    int unsigned v;
    fb = $countones(s & 16'hB400) % 2;
    v  = ((int'(s) * 2) + fb) % 65536;
    return v[15:0];
  endfunction

  task automatic model_edge();
    logic [15:0] n;
    if (reset) begin
      m_seed  = (seed_in == 16'h0000) ? 16'hABCD : seed_in;
      m_state = m_seed;
      m_cnt   = 16'd0;
      m_wrap  = 1'b0;
    end else if (enable) begin
      n       = ref_next(m_state);
      m_wrap  = (n == m_seed);
      m_cnt   = m_wrap ? 16'd0 : m_cnt + 16'd1;
      m_state = n;
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare all outputs against the model.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "_state"}, state, m_state);
    check({tag, "_wrap"}, {15'd0, wrap}, {15'd0, m_wrap});
    check({tag, "_cnt"}, step_cnt, m_cnt);
  endtask

  initial begin
    logic [15:0] frz_state, frz_cnt;
    int          wraps;

    m_state = '0; m_seed = '0; m_cnt = '0; m_wrap = 1'b0;
    reset = 1'b1; enable = 1'b0; seed_in = 16'hABCD;

    // Reset load
    tick("rst");
    check("rst_abcd", state, 16'hABCD);
    check("rst_cnt0", step_cnt, 16'd0);

    // First steps from ABCD
    exp_q.push_back(16'h579A);
    exp_q.push_back(16'hAF34);
    reset = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick("seq");
      check("seq_known", state, exp_q.pop_front());
      check("seq_cnt", step_cnt, 16'(i));
    end

    // Random enable pattern
    for (int i = 0; i < 200; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      tick("rnd");
    end

    // Hold for 5 cycles
    frz_state = state; frz_cnt = step_cnt;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick("hold");
      check("hold_state", state, frz_state);
      check("hold_cnt", step_cnt, frz_cnt);
    end
    enable = 1'b1;
    tick("resume");
    check("resume_state", state, ref_next(frz_state));
    check("resume_cnt", step_cnt, frz_cnt + 16'd1);

    // Zero seed remapped
    reset = 1'b1; seed_in = 16'h0000;
    tick("zseed");
    check("zseed_abcd", state, 16'hABCD);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      enable = ($urandom_range(0, 1) != 0);
      tick("zrun");
      vectors++;
      assert (state !== 16'h0000) else begin
        miscompares++;
        $error("FAIL zrun_nonzero: observed %h expected nonzero", state);
      end
    end

    // Reset mid-run wins over enable
    enable = 1'b1; reset = 1'b1; seed_in = 16'h1234;
    tick("midrst");
    check("midrst_1234", state, 16'h1234);
    check("midrst_cnt0", step_cnt, 16'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick("midrun");

    // Several random non-zero seeds
    for (int s = 0; s < 4; s++) begin
      reset = 1'b1; seed_in = 16'($urandom_range(1, 65535));
      tick("rseed");
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
        enable = ($urandom_range(0, 4) != 0);
        tick("rseed_run");
      end
    end

    // Full period from seed 0001
    reset = 1'b1; enable = 1'b1; seed_in = 16'h0001;
    tick("per_rst");
    reset = 1'b0;
    seen[16'h0001] = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 65535; k++) begin
      tick("per");
      if (wrap) wraps++;
      if (k == 65534) check("per_peak", step_cnt, 16'd65534);
      if (k < 65535) begin
        vectors++;
        assert (!seen[state] && state !== 16'h0000) else begin
          miscompares++;
          $error("FAIL per_repeat: observed %h at step %0d expected unseen nonzero", state, k);
        end
        seen[state] = 1'b1;
      end
    end
    check("per_end_state", state, 16'h0001);
    check("per_end_wrap", {15'd0, wrap}, 16'd1);
    check("per_end_cnt", step_cnt, 16'd0);
    check("per_wraps", 16'(wraps), 16'd1);

    // Step after wrap: pulse drops, counter restarts
    tick("postwrap");
    check("postwrap_wrap", {15'd0, wrap}, 16'd0);
    check("postwrap_cnt", step_cnt, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
